// File: rtl/async_operator_buf.sv
// async_operator_buf: req/ack join of up to four inputs, one arithmetic op, a depth-entry
// result FIFO, and a fork whose consumers are acked independently from the FIFO head.
// Optional feature: define ASYNC_OP_TOKEN_CNT_EN to add the 32-bit token_cnt pop counter port.
module async_operator_buf #(
  parameter int unsigned           data_width  = 32,
  parameter string                 op          = "reg",
  parameter logic [data_width-1:0] immediate   = '0,
  parameter int unsigned           input_size  = 1,
  parameter int unsigned           output_size = 1,
  parameter int unsigned           depth       = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [input_size-1:0]            req_l,
  input  logic [input_size-1:0]            ack_l,
  input  logic [data_width*input_size-1:0] din,
  input  logic [output_size-1:0]           req_r,
  output logic [output_size-1:0]           ack_r,
  output logic [data_width-1:0]            dout
`ifdef ASYNC_OP_TOKEN_CNT_EN
  ,
  output logic [31:0]                      token_cnt
`endif
);

  localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CntW = $clog2(depth + 1);

  typedef enum logic [2:0] {OpPass, OpAddi, OpSubi, OpMuli, OpAdd, OpSub, OpMul} op_e;

  // Unknown op names fall back to a plain pass-through of slice 0.
  localparam op_e OpSel = (op == "addi") ? OpAddi :
                          (op == "subi") ? OpSubi :
                          (op == "muli") ? OpMuli :
                          (op == "add")  ? OpAdd  :
                          (op == "sub")  ? OpSub  :
                          (op == "mul")  ? OpMul  : OpPass;

  logic [input_size-1:0]  has_q, has_d;
  logic [input_size-1:0]  req_l_q, req_l_d;
  logic [input_size-1:0]  cap;
  logic [data_width-1:0]  din_r_q [input_size];
  logic [data_width-1:0]  result;

  logic [data_width-1:0]  mem_q [depth];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   full, empty, push, pop;

  logic [output_size-1:0] served_q, served_d;
  logic [output_size-1:0] ack_r_q, ack_r_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full  = (cnt_q == CntW'(depth));
  assign empty = (cnt_q == '0);
  // served is only ever set while the FIFO holds a token, so all-ones implies non-empty.
  assign pop   = &served_q;
  // A pop on the same edge frees the slot a full FIFO needs.
  assign push  = (&has_q) && (!full || pop);

  // Per-input request/holding handshake; an ack while already holding is ignored.
  always_comb begin
    has_d   = has_q;
    req_l_d = req_l_q;
    cap     = '0;
    for (int unsigned i = 0; i < input_size; i++) begin
      if (push) begin
        has_d[i]   = 1'b0;
        req_l_d[i] = 1'b1;
      end else if (ack_l[i] && !has_q[i]) begin
        cap[i]     = 1'b1;
        has_d[i]   = 1'b1;
        req_l_d[i] = 1'b0;
      end else if (!has_q[i] && !req_l_q[i]) begin
        req_l_d[i] = 1'b1;
      end
    end
  end

  // Operator applied to the captured operands, truncated to data_width.
  always_comb begin
    result = din_r_q[0];
    case (OpSel)
      OpAddi:  result = din_r_q[0] + immediate;
      OpSubi:  result = din_r_q[0] - immediate;
      OpMuli:  result = din_r_q[0] * immediate;
      OpAdd:   for (int unsigned k = 1; k < input_size; k++) result = result + din_r_q[k];
      OpSub:   for (int unsigned k = 1; k < input_size; k++) result = result - din_r_q[k];
      OpMul:   for (int unsigned k = 1; k < input_size; k++) result = result * din_r_q[k];
      default: result = din_r_q[0];
    endcase
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Fork: each consumer takes the head once; the head pops when every consumer has it.
  always_comb begin
    served_d = served_q;
    ack_r_d  = '0;
    if (pop) begin
      served_d = '0;
    end else begin
      for (int unsigned j = 0; j < output_size; j++) begin
        if (!empty && !served_q[j] && req_r[j] && !ack_r_q[j]) begin
          ack_r_d[j]  = 1'b1;
          served_d[j] = 1'b1;
        end
      end
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      has_q    <= '0;
      req_l_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      served_q <= '0;
      ack_r_q  <= '0;
    end else begin
      has_q    <= has_d;
      req_l_q  <= req_l_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      served_q <= served_d;
      ack_r_q  <= ack_r_d;
    end
  end

  // Datapath storage; contents are don't-care while the matching valid state is clear.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < input_size; i++) begin
      if (cap[i]) din_r_q[i] <= din[data_width*i +: data_width];
    end
    if (push) mem_q[wr_ptr_q] <= result;
  end

  assign req_l = req_l_q;
  assign ack_r = ack_r_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

`ifdef ASYNC_OP_TOKEN_CNT_EN
  logic [31:0] token_cnt_q;

  // Counts popped tokens, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      token_cnt_q <= '0;
    end else if (pop) begin
      token_cnt_q <= token_cnt_q + 32'd1;
    end
  end

  assign token_cnt = token_cnt_q;
`endif

endmodule

// File: tb/tb_async_operator_buf.sv
// Bench for async_operator_buf: four instances (addi pipeline, sub join/fork/reset,
// 8-bit mul join, 8-bit muli with random consumers) checked against expected token lists.
module tb_async_operator_buf;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: addi imm=2, 1 in, 1 out, depth 1.
  logic [0:0]  a_req_l, a_ack_l, a_req_r, a_ack_r;
  logic [31:0] a_din, a_dout;
  // Instance B: sub, 2 in, 3 out, depth 4.
  logic [1:0]  b_req_l, b_ack_l;
  logic [2:0]  b_req_r, b_ack_r;
  logic [63:0] b_din;
  logic [31:0] b_dout;
  // Instance C: 8-bit mul, 3 in, 1 out, depth 2.
  logic [2:0]  c_req_l, c_ack_l;
  logic [0:0]  c_req_r, c_ack_r;
  logic [23:0] c_din;
  logic [7:0]  c_dout;
  // Instance D: 8-bit muli imm=3, 1 in, 2 out, depth 3.
  logic [0:0]  d_req_l, d_ack_l;
  logic [1:0]  d_req_r, d_ack_r;
  logic [7:0]  d_din, d_dout;
`ifdef ASYNC_OP_TOKEN_CNT_EN
  logic [31:0] a_cnt, b_cnt, c_cnt, d_cnt;
`endif

  async_operator_buf #(.data_width(32), .op("addi"), .immediate(32'd2), .input_size(1),
                       .output_size(1), .depth(1)) u_a (
    .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din),
    .req_r(a_req_r), .ack_r(a_ack_r), .dout(a_dout)
`ifdef ASYNC_OP_TOKEN_CNT_EN
    , .token_cnt(a_cnt)
`endif
  );

  async_operator_buf #(.data_width(32), .op("sub"), .immediate(32'd0), .input_size(2),
                       .output_size(3), .depth(4)) u_b (
    .clk(clk), .rst(rst), .req_l(b_req_l), .ack_l(b_ack_l), .din(b_din),
    .req_r(b_req_r), .ack_r(b_ack_r), .dout(b_dout)
`ifdef ASYNC_OP_TOKEN_CNT_EN
    , .token_cnt(b_cnt)
`endif
  );

  async_operator_buf #(.data_width(8), .op("mul"), .immediate(8'd0), .input_size(3),
                       .output_size(1), .depth(2)) u_c (
    .clk(clk), .rst(rst), .req_l(c_req_l), .ack_l(c_ack_l), .din(c_din),
    .req_r(c_req_r), .ack_r(c_ack_r), .dout(c_dout)
`ifdef ASYNC_OP_TOKEN_CNT_EN
    , .token_cnt(c_cnt)
`endif
  );

  async_operator_buf #(.data_width(8), .op("muli"), .immediate(8'd3), .input_size(1),
                       .output_size(2), .depth(3)) u_d (
    .clk(clk), .rst(rst), .req_l(d_req_l), .ack_l(d_ack_l), .din(d_din),
    .req_r(d_req_r), .ack_r(d_ack_r), .dout(d_dout)
`ifdef ASYNC_OP_TOKEN_CNT_EN
    , .token_cnt(d_cnt)
`endif
  );

  // Producer stimulus queues, per-input extra ack latency, and consumer records.
  logic [31:0] a_src[1][$];
  logic [31:0] b_src[2][$];
  logic [31:0] c_src[3][$];
  logic [31:0] d_src[1][$];
  int          b_lat[2];
  int          c_lat[3];
  logic [31:0] a_rec[$];
  int          a_at[$];
  logic [31:0] b_rec[3][$];
  logic [31:0] c_rec[$];
  logic [31:0] d_rec[2][$];
  logic [31:0] a_exp[$], b_exp[$], c_exp[$], d_exp[$];
  int          b_base[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Producers: notice req, then ack one cycle later (plus optional latency) with the next token.
  initial begin
    bit seen;
    seen = 1'b0; a_ack_l = '0; a_din = '0;
    forever begin
      @(posedge clk); #1;
      a_ack_l = '0;
      if (seen) begin
        seen = 1'b0;
        if (a_req_l[0]) begin a_ack_l[0] = 1'b1; a_din = a_src[0].pop_front(); end
      end else if (a_req_l[0] && a_src[0].size() > 0) seen = 1'b1;
    end
  end

  initial begin
    bit seen [2];
    int wait_n [2];
    b_ack_l = '0; b_din = '0;
    for (int i = 0; i < 2; i++) begin seen[i] = 1'b0; wait_n[i] = 0; end
    forever begin
      @(posedge clk); #1;
      b_ack_l = '0;
      for (int i = 0; i < 2; i++) begin
        if (seen[i]) begin
          if (!b_req_l[i]) seen[i] = 1'b0;
          else if (wait_n[i] > 0) wait_n[i]--;
          else begin
            b_ack_l[i] = 1'b1; b_din[32*i +: 32] = b_src[i].pop_front(); seen[i] = 1'b0;
          end
        end else if (b_req_l[i] && b_src[i].size() > 0) begin
          seen[i] = 1'b1; wait_n[i] = b_lat[i];
        end
      end
    end
  end

  initial begin
    bit seen [3];
    int wait_n [3];
    c_ack_l = '0; c_din = '0;
    for (int i = 0; i < 3; i++) begin seen[i] = 1'b0; wait_n[i] = 0; end
    forever begin
      @(posedge clk); #1;
      c_ack_l = '0;
      for (int i = 0; i < 3; i++) begin
        if (seen[i]) begin
          if (!c_req_l[i]) seen[i] = 1'b0;
          else if (wait_n[i] > 0) wait_n[i]--;
          else begin
            c_ack_l[i] = 1'b1; c_din[8*i +: 8] = 8'(c_src[i].pop_front()); seen[i] = 1'b0;
          end
        end else if (c_req_l[i] && c_src[i].size() > 0) begin
          seen[i] = 1'b1; wait_n[i] = c_lat[i];
        end
      end
    end
  end

  initial begin
    bit seen;
    seen = 1'b0; d_ack_l = '0; d_din = '0;
    forever begin
      @(posedge clk); #1;
      d_ack_l = '0;
      if (seen) begin
        seen = 1'b0;
        if (d_req_l[0]) begin d_ack_l[0] = 1'b1; d_din = 8'(d_src[0].pop_front()); end
      end else if (d_req_l[0] && d_src[0].size() > 0) seen = 1'b1;
    end
  end

  // Instance D consumers request at random.
  initial begin
    d_req_r = '0;
    forever begin
      @(posedge clk); #1;
      d_req_r = 2'($urandom);
    end
  end

  // Consumers take the token on every ack pulse.
  always @(negedge clk) begin
    if (a_ack_r[0]) begin a_rec.push_back(a_dout); a_at.push_back(cyc); end
    for (int j = 0; j < 3; j++) if (b_ack_r[j]) b_rec[j].push_back(b_dout);
    if (c_ack_r[0]) c_rec.push_back(32'(c_dout));
    for (int j = 0; j < 2; j++) if (d_ack_r[j]) d_rec[j].push_back(32'(d_dout));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, y, z;
    rst = 1'b0;
    a_req_r = 1'b1; b_req_r = '0; c_req_r = 1'b1;
    b_lat[0] = 0; b_lat[1] = 0;
    c_lat[0] = 0; c_lat[1] = 2; c_lat[2] = 1;
    #2;
    check("rst_a_req_l", 32'(a_req_l), 32'd0);
    check("rst_a_dout", a_dout, 32'd0);
    check("rst_b_req_l", 32'(b_req_l), 32'd0);
    check("rst_b_ack_r", 32'(b_ack_r), 32'd0);
    check("rst_b_dout", b_dout, 32'd0);
    check("rst_d_ack_r", 32'(d_ack_r), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("first_a_req_l", 32'(a_req_l), 32'd1);
    check("first_c_req_l", 32'(c_req_l), 32'd7);

    // A: 0..99 then wrap value and randoms, each +2 mod 2^32.
    for (int k = 0; k < 100; k++) begin
      a_src[0].push_back(32'(k)); a_exp.push_back(32'(k + 2));
    end
    a_src[0].push_back(32'hFFFF_FFFF); a_exp.push_back(32'd1);
    for (int k = 0; k < 19; k++) begin
      x = $urandom; a_src[0].push_back(x); a_exp.push_back(x + 32'd2);
    end
    for (int n = 0; n < 4000 && a_rec.size() < 120; n++) @(posedge clk);
    check("a_count", 32'(a_rec.size()), 32'd120);
    for (int k = 0; k < a_rec.size() && k < 120; k++)
      check($sformatf("a_data[%0d]", k), a_rec[k], a_exp[k]);
    for (int k = 5; k < a_at.size() && k < 120; k++)
      check($sformatf("a_spacing[%0d]", k), 32'(a_at[k] - a_at[k-1]), 32'd3);

    // C: 8-bit three-way product.
    c_src[0].push_back(32'd16); c_src[1].push_back(32'd16); c_src[2].push_back(32'd2);
    c_exp.push_back(32'd0);
    for (int k = 0; k < 15; k++) begin
      x = $urandom_range(255); y = $urandom_range(255); z = $urandom_range(255);
      c_src[0].push_back(x); c_src[1].push_back(y); c_src[2].push_back(z);
      c_exp.push_back((x * y * z) & 32'hFF);
    end
    for (int n = 0; n < 3000 && c_rec.size() < 16; n++) @(posedge clk);
    check("c_count", 32'(c_rec.size()), 32'd16);
    for (int k = 0; k < c_rec.size() && k < 16; k++)
      check($sformatf("c_data[%0d]", k), c_rec[k], c_exp[k]);

    // D: 8-bit times 3, two randomly requesting consumers, depth 3.
    d_src[0].push_back(32'd100); d_exp.push_back(32'd44);
    for (int k = 0; k < 40; k++) begin
      x = $urandom_range(255); d_src[0].push_back(x); d_exp.push_back((x * 3) & 32'hFF);
    end
    for (int n = 0; n < 6000 && (d_rec[0].size() < 41 || d_rec[1].size() < 41); n++)
      @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("d_count_c%0d", j), 32'(d_rec[j].size()), 32'd41);
      for (int k = 0; k < d_rec[j].size() && k < 41; k++)
        check($sformatf("d_data_c%0d[%0d]", j, k), d_rec[j][k], d_exp[k]);
    end
`ifdef ASYNC_OP_TOKEN_CNT_EN
    repeat (4) @(posedge clk);
    check("a_token_cnt", a_cnt, 32'd120);
    check("c_token_cnt", c_cnt, 32'd16);
    check("d_token_cnt", d_cnt, 32'd41);
`endif

    // B join: slice1 producer is slow; operand order s0 - s1.
    b_lat[1] = 5; b_req_r = 3'b111;
    b_src[0].push_back(32'd10); b_src[0].push_back(32'd20);
    b_src[1].push_back(32'd3);  b_src[1].push_back(32'd25);
    b_exp.push_back(32'd7); b_exp.push_back(32'hFFFF_FFFB);
    for (int n = 0; n < 500 && (b_rec[0].size() < 2 || b_rec[1].size() < 2 ||
                                b_rec[2].size() < 2); n++) @(posedge clk);
    repeat (5) @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("b_join_n%0d", j), 32'(b_rec[j].size()), 32'd2);
      for (int k = 0; k < 2 && k < b_rec[j].size(); k++)
        check($sformatf("b_join_c%0d[%0d]", j, k), b_rec[j][k], b_exp[k]);
      b_base[j] = b_rec[j].size();
    end

    // B fork: consumer 2 idle, so the head cannot pop and upstream fills FIFO plus holding regs.
    b_lat[1] = 0; b_exp.delete(); b_req_r = 3'b011;
    for (int k = 0; k < 10; k++) begin
      x = $urandom; y = $urandom;
      b_src[0].push_back(x); b_src[1].push_back(y); b_exp.push_back(x - y);
    end
    repeat (30) @(posedge clk); #1;
    check("b_fork_n0", 32'(b_rec[0].size() - b_base[0]), 32'd1);
    check("b_fork_n1", 32'(b_rec[1].size() - b_base[1]), 32'd1);
    check("b_fork_n2", 32'(b_rec[2].size() - b_base[2]), 32'd0);
    check("b_stall_src0", 32'(b_src[0].size()), 32'd5);
    check("b_stall_src1", 32'(b_src[1].size()), 32'd5);
    check("b_stall_req_l", 32'(b_req_l), 32'd0);
    check("b_stall_head", b_dout, b_exp[0]);
    b_req_r = 3'b111;
    for (int n = 0; n < 1000 && (b_rec[0].size() - b_base[0] < 10 ||
         b_rec[1].size() - b_base[1] < 10 || b_rec[2].size() - b_base[2] < 10); n++)
      @(posedge clk);
    repeat (5) @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("b_fork_total%0d", j), 32'(b_rec[j].size() - b_base[j]), 32'd10);
      for (int k = 0; k < 10 && b_base[j] + k < b_rec[j].size(); k++)
        check($sformatf("b_fork_c%0d[%0d]", j, k), b_rec[j][b_base[j] + k], b_exp[k]);
    end

    // B mid-operation reset with three tokens queued and an ack pulse in flight.
    b_exp.delete(); b_req_r = '0;
    for (int k = 0; k < 3; k++) begin
      x = $urandom; y = $urandom;
      b_src[0].push_back(x); b_src[1].push_back(y); b_exp.push_back(x - y);
    end
    repeat (20) @(posedge clk); #1;
    check("b_pre_rst_head", b_dout, b_exp[0]);
    check("b_pre_rst_req_l", 32'(b_req_l), 32'd3);
    b_req_r = 3'b001;
    @(posedge clk); #1;
    check("b_pre_rst_ack", 32'(b_ack_r), 32'd1);
    rst = 1'b0;
    #1;
    check("b_rst_ack_r", 32'(b_ack_r), 32'd0);
    check("b_rst_req_l", 32'(b_req_l), 32'd0);
    check("b_rst_dout", b_dout, 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 3; j++) b_base[j] = b_rec[j].size();
    x = $urandom; y = $urandom;
    b_src[0].push_back(x); b_src[1].push_back(y);
    b_req_r = 3'b111;
    for (int n = 0; n < 200 && (b_rec[0].size() == b_base[0] || b_rec[1].size() == b_base[1]
                                || b_rec[2].size() == b_base[2]); n++) @(posedge clk);
    repeat (10) @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("b_post_rst_n%0d", j), 32'(b_rec[j].size() - b_base[j]), 32'd1);
      if (b_rec[j].size() > b_base[j])
        check($sformatf("b_post_rst_c%0d", j), b_rec[j][b_base[j]], x - y);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
